sd_block_responder: RTL and testbench



---
 rtl/sd_block_pkg.sv | 30 +++
 rtl/sd_req_arbiter.sv | 61 ++++++
 rtl/sd_block_responder.sv | 203 ++++++++++++++++++++
 tb/tb_sd_block_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_block_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_block_pkg                                                         |
// | Shared types and constants for the sector-buffer block responder.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sd_block_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        RD_XFER   = 3'd2,
        WR_ADDR   = 3'd3,
        WR_DATA   = 3'd4,
        WR_SEND   = 3'd5,
        DONE_WAIT = 3'd6,
        RELEASE   = 3'd7
    } state_t;

    localparam int BLK_BYTES = 512;
    localparam int BUF_AW    = 9;
    localparam int CNT_W     = 10;
    localparam int DRV_W     = 2;

    localparam int DRV_FLOPPY1 = 0;
    localparam int DRV_HDD     = 1;
    localparam int DRV_FLOPPY2 = 2;

endpackage : sd_block_pkg
`default_nettype wire

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_req_arbiter                                                       |
// | Round-robin grant over the drive request lines; the search starts    |
// | just after the last granted drive.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sd_req_arbiter
    import sd_block_pkg::*;
#(
    parameter int NUM_DRIVES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_DRIVES-1:0] i_req,
    input  logic                  i_update,
    input  logic [DRV_W-1:0]      i_update_idx,
    output logic [NUM_DRIVES-1:0] o_grant,
    output logic [DRV_W-1:0]      o_grant_idx,
    output logic                  o_any
);

    logic [DRV_W-1:0] r_last;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [DRV_W-1:0] w_hi_idx;
    logic [DRV_W-1:0] w_lo_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= DRV_W'(NUM_DRIVES - 1);
        end else if (i_update) begin
            r_last <= i_update_idx;
        end
    end

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (i > int'(r_last)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = DRV_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = DRV_W'(i);
                end
            end
        end
    end

    assign o_any       = w_hi_found | w_lo_found;
    assign o_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    assign o_grant     = o_any ? (NUM_DRIVES'(1) << o_grant_idx) : '0;

endmodule : sd_req_arbiter
`default_nettype wire

// File: rtl/sd_block_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_block_responder                                                   |
// | Serves sd_rd/sd_wr sector requests by moving one 512-byte block      |
// | between the host block stream and the requester's sector buffer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sd_block_responder
    import sd_block_pkg::*;
#(
    parameter int NUM_DRIVES     = 3,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_DRIVES-1:0]    sd_rd,
    input  logic [NUM_DRIVES-1:0]    sd_wr,
    input  logic [NUM_DRIVES*32-1:0] sd_lba,
    output logic [NUM_DRIVES-1:0]    sd_ack,
    output logic [BUF_AW-1:0]        sd_buff_addr,
    output logic [7:0]               sd_buff_dout,
    input  logic [NUM_DRIVES*8-1:0]  sd_buff_din,
    output logic                     sd_buff_wr,
    output logic                     host_cmd_valid,
    input  logic                     host_cmd_ready,
    output logic                     host_cmd_write,
    output logic [1:0]               host_cmd_drive,
    output logic [31:0]              host_cmd_lba,
    input  logic                     host_rx_valid,
    output logic                     host_rx_ready,
    input  logic [7:0]               host_rx_data,
    output logic                     host_tx_valid,
    input  logic                     host_tx_ready,
    output logic [7:0]               host_tx_data,
    input  logic                     host_done,
    output logic                     busy,
    output logic                     err
);

    localparam int                 c_TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_BLK       = CNT_W'(BLK_BYTES);
    localparam logic [CNT_W-1:0]   c_LAST_BYTE = CNT_W'(BLK_BYTES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [NUM_DRIVES-1:0]   r_grant;
    logic [NUM_DRIVES-1:0]   r_ack;
    logic [DRV_W-1:0]        r_drive;
    logic                    r_write;
    logic [31:0]             r_lba;
    logic [CNT_W-1:0]        r_count;
    logic [BUF_AW-1:0]       r_wr_addr;
    logic [7:0]              r_dout;
    logic                    r_buff_wr;
    logic [7:0]              r_tx_data;
    logic                    r_err;
    logic [c_TMR_W-1:0]      r_timer;

    logic [NUM_DRIVES-1:0]   w_req;
    logic [NUM_DRIVES-1:0]   w_grant;
    logic [DRV_W-1:0]        w_grant_idx;
    logic                    w_any;
    logic [7:0]              w_din;
    logic [31:0]             w_lba;
    logic                    w_rx_fire;
    logic                    w_tx_fire;
    logic                    w_timeout;
    logic                    w_err;

    assign w_req = (sd_rd | sd_wr) & ~r_ack;

    sd_req_arbiter #(
        .NUM_DRIVES (NUM_DRIVES)
    ) u_arbiter (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req        (w_req),
        .i_update     (r_state == RELEASE),
        .i_update_idx (r_drive),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_din = '0;
        w_lba = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (r_drive == DRV_W'(i)) w_din = sd_buff_din[i*8 +: 8];
            if (w_grant[i])           w_lba = sd_lba[i*32 +: 32];
        end
    end

    assign host_rx_ready = (r_state == RD_XFER) && (r_count < c_BLK);
    assign host_tx_valid = (r_state == WR_SEND);
    assign w_rx_fire     = host_rx_valid && host_rx_ready;
    assign w_tx_fire     = host_tx_valid && host_tx_ready;
    assign w_timeout     = (r_state != IDLE) && (r_timer == c_TMR_LAST);

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            IDLE:      if (w_any) w_next = CMD;
            CMD:       if (host_cmd_ready) w_next = r_write ? WR_ADDR : RD_XFER;
            RD_XFER: begin
                if (w_rx_fire && r_count == c_LAST_BYTE) begin
                    w_next = host_done ? RELEASE : DONE_WAIT;
                end else if (host_done) begin
                    w_next = RELEASE;
                    w_err  = 1'b1;
                end
            end
            WR_ADDR, WR_DATA: begin
                if (host_done) begin
                    w_next = RELEASE;
                    w_err  = 1'b1;
                end else begin
                    w_next = (r_state == WR_ADDR) ? WR_DATA : WR_SEND;
                end
            end
            WR_SEND: begin
                if (w_tx_fire && r_count == c_LAST_BYTE) begin
                    w_next = host_done ? RELEASE : DONE_WAIT;
                end else if (host_done) begin
                    w_next = RELEASE;
                    w_err  = 1'b1;
                end else if (w_tx_fire) begin
                    w_next = WR_ADDR;
                end
            end
            DONE_WAIT: if (host_done) w_next = RELEASE;
            RELEASE:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        // Only a state that is genuinely stalled can time out.
        if (w_timeout && w_next == r_state && !w_rx_fire && !w_tx_fire) begin
            w_next = RELEASE;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ack     <= '0;
            r_drive   <= '0;
            r_write   <= 1'b0;
            r_lba     <= '0;
            r_count   <= '0;
            r_wr_addr <= '0;
            r_dout    <= '0;
            r_buff_wr <= 1'b0;
            r_tx_data <= '0;
            r_err     <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_next;
            r_err     <= w_err;
            r_buff_wr <= w_rx_fire;
            if (w_rx_fire) begin
                r_wr_addr <= r_count[BUF_AW-1:0];
                r_dout    <= host_rx_data;
            end
            if (r_state == IDLE && w_any) begin
                r_grant <= w_grant;
                r_drive <= w_grant_idx;
                r_write <= |(sd_wr & w_grant);
                r_lba   <= w_lba;
            end
            if (r_state == CMD && host_cmd_ready) begin
                r_ack   <= r_grant;
                r_count <= '0;
            end else if (w_rx_fire || w_tx_fire) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state == WR_DATA) r_tx_data <= w_din;
            if (r_state == RELEASE) r_ack <= '0;
            if (r_state == IDLE || w_next != r_state || w_rx_fire || w_tx_fire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

    // Reads drive the address from the accepted-byte register, writes from the live count.
    assign sd_buff_addr   = r_write ? r_count[BUF_AW-1:0] : r_wr_addr;
    assign sd_buff_dout   = r_dout;
    assign sd_buff_wr     = r_buff_wr;
    assign sd_ack         = r_ack;
    assign host_cmd_valid = (r_state == CMD);
    assign host_cmd_write = r_write;
    assign host_cmd_drive = r_drive;
    assign host_cmd_lba   = r_lba;
    assign host_tx_data   = r_tx_data;
    assign busy           = (r_state != IDLE);
    assign err            = r_err;

endmodule : sd_block_responder
`default_nettype wire

// File: tb/tb_sd_block_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_block_responder                                                |
// | Randomized bench with buffer/host models and a round-robin model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sd_block_responder;

    localparam int N   = 3;
    localparam int TMO = 64;
    localparam int BLK = 512;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   sd_rd, sd_wr, sd_ack;
    logic [N*32-1:0] sd_lba;
    logic [8:0]     sd_buff_addr;
    logic [7:0]     sd_buff_dout;
    logic [N*8-1:0] sd_buff_din;
    logic           sd_buff_wr;
    logic           host_cmd_valid, host_cmd_ready, host_cmd_write;
    logic [1:0]     host_cmd_drive;
    logic [31:0]    host_cmd_lba;
    logic           host_rx_valid, host_rx_ready;
    logic [7:0]     host_rx_data;
    logic           host_tx_valid, host_tx_ready;
    logic [7:0]     host_tx_data;
    logic           host_done, busy, err;

    always #5 clk = ~clk;

    sd_block_responder #(
        .NUM_DRIVES     (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_lba         (sd_lba),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_buff_dout   (sd_buff_dout),
        .sd_buff_din    (sd_buff_din),
        .sd_buff_wr     (sd_buff_wr),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_ready (host_cmd_ready),
        .host_cmd_write (host_cmd_write),
        .host_cmd_drive (host_cmd_drive),
        .host_cmd_lba   (host_cmd_lba),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .host_rx_data   (host_rx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_tx_data   (host_tx_data),
        .host_done      (host_done),
        .busy           (busy),
        .err            (err)
    );

    // Requester sector buffers: registered read, writes logged per transaction.
    logic [31:0] lba_of  [N];
    logic [7:0]  bufmem  [N][BLK];
    logic [7:0]  din_q   [N];
    logic [7:0]  wmem    [N][BLK];
    int          wtag    [N][BLK];
    int          wcnt    [N];
    int          txn;
    int          err_cnt;
    int          ack_bad;

    assign sd_lba      = {lba_of[2], lba_of[1], lba_of[0]};
    assign sd_buff_din = {din_q[2], din_q[1], din_q[0]};

    always @(posedge clk) begin
        for (int d = 0; d < N; d++) din_q[d] <= bufmem[d][sd_buff_addr];
    end

    always @(negedge clk) begin
        if (err) err_cnt = err_cnt + 1;
        if ($countones(sd_ack) > 1) ack_bad = ack_bad + 1;
        if (sd_buff_wr) begin
            for (int d = 0; d < N; d++) begin
                if (sd_ack[d]) begin
                    wmem[d][sd_buff_addr] = sd_buff_dout;
                    wtag[d][sd_buff_addr] = txn;
                    wcnt[d] = wcnt[d] + 1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_grant;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pre_byte(input int d, input int a);
        return 8'hA5 ^ 8'(a) ^ 8'(d * 17);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_grant + k) % N;
            if ((m & (N'(1) << c)) != '0) return c;
        end
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_grant = N - 1;
    endtask

    task automatic start_txn(output int drv, output bit wr);
        logic [N-1:0] pend;
        pend = sd_rd | sd_wr;
        drv  = rr_pick(pend);
        wr   = sd_wr[drv];
        txn++;
        for (int i = 0; i < 16 && !host_cmd_valid; i++) @(negedge clk);
        check_eq("cmd_valid", 64'(host_cmd_valid), 64'd1);
        check_eq("cmd_drive", 64'(host_cmd_drive), 64'(drv));
        check_eq("cmd_write", 64'(host_cmd_write), 64'(wr));
        check_eq("cmd_lba", 64'(host_cmd_lba), 64'(lba_of[drv]));
        host_cmd_ready = 1'b1;
        @(negedge clk);
        host_cmd_ready = 1'b0;
        check_eq("ack_rise", 64'(sd_ack), 64'd1 << drv);
        sd_rd[drv] = 1'b0;
        sd_wr[drv] = 1'b0;
    endtask

    task automatic host_read(input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 4000) begin
            host_rx_valid = ($urandom_range(0, 3) != 0);
            host_rx_data  = 8'(sent);
            if (host_rx_valid && host_rx_ready) sent++;
            @(negedge clk);
            guard++;
        end
        host_rx_valid = 1'b0;
        check_eq("rx_accepted", 64'(sent), 64'(n));
    endtask

    task automatic host_write(input int drv, input bit rand_rdy, output int cycles);
        int k = 0;
        int bad = 0;
        cycles = 0;
        while (k < BLK && cycles < 8000) begin
            host_tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            cycles++;
            if (host_tx_valid && host_tx_ready) begin
                if (host_tx_data !== pre_byte(drv, k)) bad++;
                k++;
            end
            if (k < BLK) @(negedge clk);
        end
        @(negedge clk);
        host_tx_ready = 1'b0;
        check_eq("tx_count", 64'(k), 64'(BLK));
        check_eq("tx_data_bad", 64'(bad), 64'd0);
    endtask

    task automatic finish_txn(input int drv);
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
        check_eq("ack_hold", 64'(sd_ack), 64'd1 << drv);
        @(negedge clk);
        check_eq("ack_fall", 64'(sd_ack), 64'd0);
        check_eq("busy_idle", 64'(busy), 64'd0);
        last_grant = drv;
    endtask

    task automatic verify_rd(input int drv, input int n, input int cnt0);
        int bad = 0;
        for (int a = 0; a < BLK; a++) begin
            if (a < n) begin
                if (wtag[drv][a] != txn || wmem[drv][a] !== 8'(a)) bad++;
            end else if (wtag[drv][a] == txn) begin
                bad++;
            end
        end
        check_eq("rd_buf_bad", 64'(bad), 64'd0);
        check_eq("rd_wr_pulses", 64'(wcnt[drv] - cnt0), 64'(n));
    endtask

    task automatic full_read();
        int drv, cnt0, rdy_hi;
        bit wr;
        start_txn(drv, wr);
        cnt0 = wcnt[drv];
        host_read(BLK);
        rdy_hi = 0;
        host_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (host_rx_ready) rdy_hi++;
        end
        host_rx_valid = 1'b0;
        check_eq("rx_surplus_ready", 64'(rdy_hi), 64'd0);
        finish_txn(drv);
        verify_rd(drv, BLK, cnt0);
    endtask

    initial begin
        int drv, cnt0, e0, cycles, elapsed;
        bit wr;
        reset_n = 1'b0;
        sd_rd = '0; sd_wr = '0;
        host_cmd_ready = 0; host_rx_valid = 0; host_rx_data = 0;
        host_tx_ready = 0; host_done = 0;
        txn = 0; err_cnt = 0; ack_bad = 0;
        for (int d = 0; d < N; d++) begin
            lba_of[d] = 32'($urandom);
            wcnt[d] = 0;
            for (int a = 0; a < BLK; a++) begin
                bufmem[d][a] = pre_byte(d, a);
                wtag[d][a] = 0;
            end
        end
        last_grant = N - 1;
        repeat (3) @(negedge clk);
        check_eq("rst_outs_a", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, host_cmd_valid, host_cmd_write, host_cmd_drive}, 64'd0);
        check_eq("rst_outs_b", {host_cmd_lba, host_rx_ready, host_tx_valid, host_tx_data, busy, err}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Read on drive 1 (HDD) with a fixed LBA.
        lba_of[1] = 32'h1234;
        sd_rd[1] = 1'b1;
        full_read();

        // Write on drive 0 with a randomly stalling host, then with ready held high.
        lba_of[0] = 32'($urandom);
        sd_wr[0] = 1'b1;
        sd_rd[0] = 1'b1;
        start_txn(drv, wr);
        host_write(drv, 1'b1, cycles);
        finish_txn(drv);
        sd_wr[0] = 1'b1;
        start_txn(drv, wr);
        host_write(drv, 1'b0, cycles);
        check_eq("wr_block_cycles", 64'(cycles), 64'd1536);
        finish_txn(drv);

        // Round robin from reset: drives 0 and 2 together, then 0 again while 2 waits.
        do_reset();
        sd_rd[0] = 1'b1;
        sd_rd[2] = 1'b1;
        full_read();
        sd_rd[0] = 1'b1;
        full_read();
        full_read();

        // Short block after 100 bytes on drive 1.
        sd_rd[1] = 1'b1;
        e0 = err_cnt;
        start_txn(drv, wr);
        cnt0 = wcnt[drv];
        host_read(100);
        finish_txn(drv);
        @(negedge clk);
        check_eq("short_err_pulses", 64'(err_cnt - e0), 64'd1);
        verify_rd(drv, 100, cnt0);

        // Host stalls mid-block on drive 2.
        sd_rd[2] = 1'b1;
        e0 = err_cnt;
        start_txn(drv, wr);
        host_read(10);
        elapsed = 1;
        while (sd_ack != '0 && elapsed < 200) begin
            @(negedge clk);
            elapsed++;
        end
        @(negedge clk);
        check_eq("tmo_window", 64'(elapsed >= TMO && elapsed <= TMO + 6), 64'd1);
        check_eq("tmo_err_pulses", 64'(err_cnt - e0), 64'd1);
        last_grant = drv;

        // Asynchronous reset in the middle of a read.
        sd_rd[0] = 1'b1;
        e0 = err_cnt;
        start_txn(drv, wr);
        host_read(50);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_a", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, host_cmd_valid, host_cmd_write, host_cmd_drive}, 64'd0);
        check_eq("async_rst_b", {host_cmd_lba, host_rx_ready, host_tx_valid, host_tx_data, busy, err}, 64'd0);
        repeat (3) @(negedge clk);
        check_eq("async_rst_no_err", 64'(err_cnt - e0), 64'd0);
        reset_n = 1'b1;
        last_grant = N - 1;
        sd_rd[1] = 1'b1;
        sd_rd[0] = 1'b1;
        start_txn(drv, wr);
        check_eq("post_rst_grant", 64'(drv), 64'd0);
        do_reset();

        check_eq("ack_onehot", 64'(ack_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule : tb_sd_block_responder
`default_nettype wire
